montgomery_exp_ctrl: RTL and testbench
======================================

Name: montgomery_exp_ctrl

Overview:
Sequencer that computes result = in_x^in_e mod in_m with left-to-right square-and-multiply. It uses a single external montgomery multiplier instance for every step and drives that multiplier's start/operand/modulus inputs. The block sits between the RSA top level and the multiplier. The host supplies the Montgomery constants R mod M and R^2 mod M, with R = 2^DATA_WIDTH.

Parameters:
DATA_WIDTH, 512, operand/modulus width; must match the multiplier.
E_WIDTH, 512, exponent width; every bit is scanned, there is no leading-zero skip.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
in_x  input  DATA_WIDTH  base, < in_m
in_e  input  E_WIDTH  exponent
in_m  input  DATA_WIDTH  odd modulus, > 1
in_r  input  DATA_WIDTH  R mod M
in_r2  input  DATA_WIDTH  R^2 mod M
result  output  DATA_WIDTH  x^e mod M; held until next accepted start
done  output  1  one-cycle pulse when result is valid
busy  output  1  high from the cycle after an accepted start until done
mm_start  output  1  one-cycle launch pulse to the multiplier
mm_a  output  DATA_WIDTH  multiplier operand A
mm_b  output  DATA_WIDTH  multiplier operand B
mm_m  output  DATA_WIDTH  multiplier modulus
mm_result  input  DATA_WIDTH  multiplier output
mm_done  input  1  multiplier completion; may be a level

Behaviour:
- Reset: result, mm_a, mm_b and mm_m are 0; done, busy and mm_start are 0; state is IDLE.
- Reset asserted in any state forces all of the above on the next edge. An in-flight multiplication is abandoned; the multiplier shares the same reset.
- Accepting start in IDLE latches in_x, in_e, in_m, in_r and in_r2 into internal registers. Inputs may change after that. start outside IDLE is ignored.
- At accept: acc <= in_r, i <= E_WIDTH-1, result <= 0.
- Each multiplication step is a launch state (L_*) followed by a wait state (W_*):
  - L_*: mm_start=1 for exactly one cycle; mm_a, mm_b and mm_m are registered in the same cycle.
  - mm_a, mm_b and mm_m stay stable until the matching W_* sees mm_done=1.
  - W_* samples mm_done only from the cycle after the launch. A stale level-high done is therefore ignored.
  - On the sampling cycle, mm_result is captured and the state transitions.
- State sequence:
  - IDLE -(start)-> L_X
  - L_X / W_X: MM(x, R2), result into xt (x in Montgomery domain) -> L_SQ
  - L_SQ / W_SQ: MM(acc, acc), result into acc -> L_MUL if e[i]=1, else STEP
  - L_MUL / W_MUL: MM(acc, xt), result into acc -> STEP
  - STEP: if i==0 -> L_OUT; else i <= i-1 -> L_SQ. STEP takes one cycle.
  - L_OUT / W_OUT: MM(acc, 1), result into result -> FIN
  - FIN: done=1, busy=0 -> IDLE
- Multiplication count = 2 + E_WIDTH + popcount(e).
- Latency from accept to done = sum over steps of (1 + Lmm) + E_WIDTH (STEP cycles) + 1. Lmm is the multiplier's launch-to-done latency in cycles.
- Boundaries:
  - e=0 gives result 1.
  - x=0 gives result 0 for e>0.
  - i uses ceil(log2(E_WIDTH)) bits; there is no underflow because STEP checks i==0 before decrementing.
  - M even or M<=1 is unsupported; output is don't-care but the FSM must still terminate.
- The block itself does no arithmetic; all modular reduction happens in the multiplier.

Decomposition:
- Package rsa_pkg holds:
  - DATA_WIDTH and E_WIDTH defaults
  - state encoding localparams (IDLE, L_X, W_X, L_SQ, W_SQ, L_MUL, W_MUL, STEP, L_OUT, W_OUT, FIN)
  - the constant ONE = {{DATA_WIDTH-1{1'b0}}, 1'b1}
- The montgomery multiplier stays outside this block; the top level wires it up. There is no internal sub-module; the FSM, operand muxes and bit counter fit in one module.

Test Plan:
1. x=2, e=5, M=13, in_r and in_r2 computed by the bench for R=2^512 -> result=6; exactly one done pulse; mm_start pulse count = 516.
2. x=7, e=0, M=13 -> result=1; mm_start pulse count = 514; no L_MUL ever visited.
3. x=3, e=1000002, M=1000003 (prime) -> result=1 (Fermat); mm_start pulse count = 522. Use a mock multiplier with Lmm=3 and done held high between jobs; verify total cycle count against the formula and that mm_a, mm_b and mm_m stay stable during each wait.
4. start held high for 4 cycles, then pulsed again mid-run -> exactly one operation; busy stays continuous; result matches scenario 1 values.
5. reset pulsed for one cycle during W_SQ at i=300 -> next edge: busy=0, mm_start=0, result=0, state IDLE. A subsequent start with scenario 1 inputs -> result=6.

Source files
------------

// File: rtl/montgomery_exp_ctrl_pkg.sv
// Shared widths, FSM state encoding and constants for the modular
// exponentiation sequencer.
package rsa_pkg;

    localparam int DATA_WIDTH_DEF = 512;
    localparam int E_WIDTH_DEF    = 512;

    typedef enum logic [3:0] {
        IDLE, L_X, W_X, L_SQ, W_SQ, L_MUL, W_MUL, STEP, L_OUT, W_OUT, FIN
    } state_t;

    localparam logic [DATA_WIDTH_DEF-1:0] ONE = {{(DATA_WIDTH_DEF-1){1'b0}}, 1'b1};

endpackage

// File: rtl/montgomery_exp_ctrl_if.sv
// Host request/response and multiplier launch/return signals of the
// exponentiation sequencer; slave is the sequencer's view.
interface montgomery_exp_ctrl_if #(
    parameter int DATA_WIDTH = 512,
    parameter int E_WIDTH    = 512
);
    logic                  start;
    logic [DATA_WIDTH-1:0] in_x;
    logic [E_WIDTH-1:0]    in_e;
    logic [DATA_WIDTH-1:0] in_m;
    logic [DATA_WIDTH-1:0] in_r;
    logic [DATA_WIDTH-1:0] in_r2;
    logic [DATA_WIDTH-1:0] result;
    logic                  done;
    logic                  busy;
    logic                  mm_start;
    logic [DATA_WIDTH-1:0] mm_a;
    logic [DATA_WIDTH-1:0] mm_b;
    logic [DATA_WIDTH-1:0] mm_m;
    logic [DATA_WIDTH-1:0] mm_result;
    logic                  mm_done;

    modport slave (
        input  start, in_x, in_e, in_m, in_r, in_r2, mm_result, mm_done,
        output result, done, busy, mm_start, mm_a, mm_b, mm_m
    );

    modport master (
        output start, in_x, in_e, in_m, in_r, in_r2, mm_result, mm_done,
        input  result, done, busy, mm_start, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external
// Montgomery multiplier; computes x^e mod m.
module montgomery_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int E_WIDTH    = E_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    montgomery_exp_ctrl_if.slave bus
);
    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [DATA_WIDTH-1:0] DW_ONE = DATA_WIDTH'(ONE);

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_acc, r_xt, r_result;
    logic [DATA_WIDTH-1:0] r_mm_a, r_mm_b, r_mm_m;
    logic [E_WIDTH-1:0]    r_e;
    logic [IW-1:0]         r_i;
    logic                  r_done, r_busy, r_mm_start;

    logic                  w_accept, w_launch;
    logic [DATA_WIDTH-1:0] w_acc_n, w_mm_a_n, w_mm_b_n;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_launch = (w_next == L_X) || (w_next == L_SQ) ||
                      (w_next == L_MUL) || (w_next == L_OUT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_acc_n  = r_acc;
        w_mm_a_n = r_mm_a;
        w_mm_b_n = r_mm_b;
        case (r_state)
            IDLE:  if (bus.start) begin
                       w_next  = L_X;
                       w_acc_n = bus.in_r;
                   end
            L_X:   w_next = W_X;
            W_X:   if (bus.mm_done) w_next = L_SQ;
            L_SQ:  w_next = W_SQ;
            W_SQ:  if (bus.mm_done) begin
                       w_acc_n = bus.mm_result;
                       w_next  = r_e[r_i] ? L_MUL : STEP;
                   end
            L_MUL: w_next = W_MUL;
            W_MUL: if (bus.mm_done) begin
                       w_acc_n = bus.mm_result;
                       w_next  = STEP;
                   end
            STEP:  w_next = (r_i == '0) ? L_OUT : L_SQ;
            L_OUT: w_next = W_OUT;
            W_OUT: if (bus.mm_done) w_next = FIN;
            FIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Operands follow the next state so they become valid in the same
        // cycle mm_start rises, using a freshly returned acc where needed.
        case (w_next)
            L_X: begin
                w_mm_a_n = bus.in_x;
                w_mm_b_n = bus.in_r2;
            end
            L_SQ: begin
                w_mm_a_n = w_acc_n;
                w_mm_b_n = w_acc_n;
            end
            L_MUL: begin
                w_mm_a_n = w_acc_n;
                w_mm_b_n = r_xt;
            end
            L_OUT: begin
                w_mm_a_n = w_acc_n;
                w_mm_b_n = DW_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_xt       <= '0;
            r_result   <= '0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
            r_e        <= '0;
            r_i        <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mm_start <= 1'b0;
        end else begin
            r_mm_start <= w_launch;
            r_mm_a     <= w_mm_a_n;
            r_mm_b     <= w_mm_b_n;
            r_acc      <= w_acc_n;
            r_done     <= (w_next == FIN);
            r_busy     <= (w_next != IDLE) && (w_next != FIN);
            // x and R^2 are consumed by the L_X operands at accept, so only
            // the exponent and modulus need holding for the whole run.
            if (w_accept) begin
                r_e      <= bus.in_e;
                r_mm_m   <= bus.in_m;
                r_i      <= IW'(E_WIDTH - 1);
                r_result <= '0;
            end
            if (r_state == W_X && bus.mm_done)   r_xt     <= bus.mm_result;
            if (r_state == STEP && r_i != '0)    r_i      <= r_i - IW'(1);
            if (r_state == W_OUT && bus.mm_done) r_result <= bus.mm_result;
        end
    end

    assign bus.result   = r_result;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.mm_start = r_mm_start;
    assign bus.mm_a     = r_mm_a;
    assign bus.mm_b     = r_mm_b;
    assign bus.mm_m     = r_mm_m;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: mock Montgomery multiplier (Lmm=3, level
// done) plus a plain-arithmetic model of operand sequence and result.
module tb_montgomery_exp_ctrl;
    import rsa_pkg::*;

    localparam int DW  = 512;
    localparam int EW  = 512;
    localparam int LMM = 3;

    typedef logic [DW-1:0] dw_t;
    typedef logic [EW-1:0] ew_t;
    typedef logic [63:0]   u64;
    typedef struct { u64 a; u64 b; } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    montgomery_exp_ctrl_if #(.DATA_WIDTH(DW), .E_WIDTH(EW)) bus ();
    montgomery_exp_ctrl #(.DATA_WIDTH(DW), .E_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input dw_t act, input dw_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // right-to-left modular power, m < 2^31 keeps products in 64 bits
    function automatic u64 powmod(input u64 b, input ew_t e, input u64 m);
        u64 r, bb;
        r  = 64'd1 % m;
        bb = b % m;
        for (int k = 0; k < EW; k++) begin
            if (e[k]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r;
    endfunction

    function automatic u64 mont(input u64 a, input u64 b, input u64 m);
        ew_t rexp;
        u64  rinv;
        if (m < 64'd2) return 64'd0;
        rexp = ew_t'(DW);
        rinv = powmod((m + 64'd1) / 64'd2, rexp, m);  // (1/2)^DW mod m
        return ((((a % m) * (b % m)) % m) * rinv) % m;
    endfunction

    // mock multiplier: done is a level held until the next launch
    int mcnt;
    u64 mres;
    always @(posedge clk) begin
        if (reset) begin
            mcnt          <= 0;
            bus.mm_done   <= 1'b0;
            bus.mm_result <= '0;
        end else if (bus.mm_start) begin
            mres        <= mont(bus.mm_a[63:0], bus.mm_b[63:0], bus.mm_m[63:0]);
            mcnt        <= LMM - 1;
            bus.mm_done <= 1'b0;
        end else if (mcnt != 0) begin
            if (mcnt == 1) begin
                bus.mm_done   <= 1'b1;
                bus.mm_result <= dw_t'(mres);
            end
            mcnt <= mcnt - 1;
        end
    end

    op_t op_q[$];
    op_t op;
    u64  exp_res, exp_m;
    int  exp_n;
    int  n_launch, n_done, busy_cyc;
    logic in_wait, seen_busy;
    dw_t ha, hb, hm;

    always @(negedge clk) begin
        if (reset) begin
            in_wait   = 1'b0;
            seen_busy = 1'b0;
        end else begin
            if (bus.mm_start) begin
                n_launch++;
                if (op_q.size() == 0) chk_i("extra_launch", n_launch, exp_n);
                else begin
                    op = op_q.pop_front();
                    chk("mm_a", bus.mm_a, dw_t'(op.a));
                    chk("mm_b", bus.mm_b, dw_t'(op.b));
                    chk("mm_m", bus.mm_m, dw_t'(exp_m));
                end
                ha = bus.mm_a; hb = bus.mm_b; hm = bus.mm_m;
                in_wait = 1'b1;
            end else if (in_wait) begin
                chk("hold_a", bus.mm_a, ha);
                chk("hold_b", bus.mm_b, hb);
                chk("hold_m", bus.mm_m, hm);
                if (bus.mm_done) in_wait = 1'b0;
            end
            if (bus.busy) begin
                seen_busy = 1'b1;
                busy_cyc++;
            end
            if (bus.done) begin
                n_done++;
                chk("result", bus.result, dw_t'(exp_res));
                chk_i("launches", n_launch, exp_n);
                chk_i("latency", busy_cyc + 1, (1 + LMM) * exp_n + EW + 1);
                chk_i("busy_in_fin", int'(bus.busy), 0);
                seen_busy = 1'b0;
            end else if (seen_busy && !bus.busy) begin
                chk_i("busy_gap", int'(bus.busy), 1);
                seen_busy = 1'b0;
            end
        end
    end

    task automatic scramble();
        for (int k = 0; k < DW / 32; k++) begin
            bus.in_x[k*32 +: 32]  = $urandom;
            bus.in_m[k*32 +: 32]  = $urandom;
            bus.in_r[k*32 +: 32]  = $urandom;
            bus.in_r2[k*32 +: 32] = $urandom;
        end
        for (int k = 0; k < EW / 32; k++) bus.in_e[k*32 +: 32] = $urandom;
    endtask

    // stop_at > 0 returns early once that many launches were seen
    task automatic run(input u64 x, input ew_t e, input u64 m, input int hold,
                       input int pulse_at, input int stop_at);
        u64  rm, r2, xt, acc, am;
        ew_t rexp;
        int  d0, cyc;
        rexp = ew_t'(DW);
        rm   = powmod(64'd2, rexp, m);
        r2   = (rm * rm) % m;
        xt   = (x * rm) % m;
        acc  = 64'd1;
        op_q.delete();
        op_q.push_back('{a: x, b: r2});
        for (int k = EW - 1; k >= 0; k--) begin
            am = (acc * rm) % m;
            op_q.push_back('{a: am, b: am});
            acc = (acc * acc) % m;
            if (e[k]) begin
                op_q.push_back('{a: (acc * rm) % m, b: xt});
                acc = (acc * x) % m;
            end
        end
        op_q.push_back('{a: (acc * rm) % m, b: 64'd1});
        exp_n    = op_q.size();
        exp_res  = powmod(x, e, m);
        exp_m    = m;
        n_launch = 0;
        busy_cyc = 0;
        d0       = n_done;

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in_x  = dw_t'(x);
        bus.in_e  = e;
        bus.in_m  = dw_t'(m);
        bus.in_r  = dw_t'(rm);
        bus.in_r2 = dw_t'(r2);
        repeat (hold) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        scramble();

        cyc = 0;
        while (n_done == d0 && cyc < 6000) begin
            if (stop_at > 0 && n_launch == stop_at) return;
            @(posedge clk); #1;
            bus.start = (cyc == pulse_at);
            cyc++;
        end
        bus.start = 1'b0;
        chk_i("done_seen", int'(n_done != d0), 1);
        repeat (3) begin @(posedge clk); #1; end
        chk_i("done_once", n_done - d0, 1);
        chk("result_held", bus.result, dw_t'(exp_res));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_result"}, bus.result, '0);
        chk({nm, "_mm_a"}, bus.mm_a, '0);
        chk({nm, "_mm_b"}, bus.mm_b, '0);
        chk({nm, "_mm_m"}, bus.mm_m, '0);
        chk_i({nm, "_ctl"}, int'({bus.done, bus.busy, bus.mm_start}), 0);
    endtask

    initial begin
        u64  m, x;
        ew_t e;
        n_done    = 0;
        bus.start = 1'b0;
        bus.in_x  = '0; bus.in_e = '0; bus.in_m = '0;
        bus.in_r  = '0; bus.in_r2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;

        chk_i("model_pow_2_5_13", int'(powmod(64'd2, ew_t'(5), 64'd13)), 6);
        chk_i("model_fermat", int'(powmod(64'd3, ew_t'(1000002), 64'd1000003)), 1);

        run(64'd2, ew_t'(5), 64'd13, 1, -1, 0);
        chk_i("s1_launches", n_launch, 516);
        chk("s1_result", bus.result, dw_t'(6));

        run(64'd7, ew_t'(0), 64'd13, 1, -1, 0);
        chk_i("s2_launches", n_launch, 514);
        chk("s2_result", bus.result, dw_t'(1));

        run(64'd3, ew_t'(1000002), 64'd1000003, 1, -1, 0);
        chk_i("s3_launches", n_launch, 522);
        chk("s3_result", bus.result, dw_t'(1));

        run(64'd2, ew_t'(5), 64'd13, 4, 100, 0);
        chk_i("s4_launches", n_launch, 516);
        chk("s4_result", bus.result, dw_t'(6));

        // abort during the squaring at i=300 (launch 213), then rerun
        run(64'd2, ew_t'(5), 64'd13, 1, -1, 213);
        chk_i("s5_reached", n_launch, 213);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("s5_rst");
        reset = 1'b0;
        run(64'd2, ew_t'(5), 64'd13, 1, -1, 0);
        chk("s5_result", bus.result, dw_t'(6));

        run(64'd0, ew_t'(9), 64'd101, 1, -1, 0);
        chk("x0_result", bus.result, '0);

        for (int t = 0; t < 7; t++) begin
            m = u64'($urandom_range(32'h3FFF_FFFF, 3) | 32'd1);
            x = u64'($urandom) % m;
            e = '0;
            for (int k = 0; k < EW / 32; k++)
                e[k*32 +: 32] = (t % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
            run(x, e, m, 1 + (t % 3), 50 + t, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
